// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: shared types and sizes for the frame-aware buffer.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
package frame_buffer_pkg;
  localparam int FRAME_WORDS    = 484;
  localparam int DEFAULT_ADDR_W = 11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;
endpackage
`default_nettype wire

// File: rtl/frame_buffer_ctrl_ram.sv
// frame_ram: simple dual-port {last,data} store with a registered read port.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module frame_ram
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: stores whole frames, drops oversize/overflowing ones,
// and streams only committed frames out through a valid/ready port. Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module frame_buffer_ctrl
  import frame_buffer_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = FRAME_WORDS
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] DIN,
  input  logic        DIN_WE,
  input  logic        DIN_LAST,
  output logic [31:0] DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        DOUT_LAST,
  output logic [2:0]  FRAMES_AVAIL,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] DROP_CNT
);
  localparam logic [8:0]        WCNT_MAX = 9'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  wstate_t           state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, wr_nx, cmt_ptr, cmt_nx, rd_ptr;
  logic [8:0]        wcnt, wcnt_nx;
  logic              ram_we, commit, drop, full;

  logic              fetch, pend, pop, last_pop;
  logic [1:0]        ocnt;
  logic [2:0]        occ_nx;
  entry_t            buf0, buf1, rdata, wdata;

  assign full  = (wr_ptr + PTR_ONE) == rd_ptr;
  assign wdata = '{last: DIN_LAST, data: DIN};

  always_comb begin
    state_nx = state;
    wr_nx    = wr_ptr;
    cmt_nx   = cmt_ptr;
    wcnt_nx  = wcnt;
    ram_we   = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
    case (state)
      W_IDLE: begin
        if (DIN_WE) begin
          if (!full) begin
            ram_we  = 1'b1;
            wr_nx   = wr_ptr + PTR_ONE;
            wcnt_nx = 9'd1;
            if (DIN_LAST) begin
              commit = 1'b1;
              cmt_nx = wr_ptr + PTR_ONE;
            end else begin
              state_nx = W_FILL;
            end
          end else if (DIN_LAST) begin
            drop = 1'b1;
          end else begin
            state_nx = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (DIN_WE) begin
          if (full || (wcnt == WCNT_MAX && !DIN_LAST)) begin
            // Rewind to the last commit so the partial frame vanishes.
            wr_nx = cmt_ptr;
            if (DIN_LAST) begin
              drop     = 1'b1;
              state_nx = W_IDLE;
            end else begin
              state_nx = W_DROP;
            end
          end else begin
            ram_we  = 1'b1;
            wr_nx   = wr_ptr + PTR_ONE;
            wcnt_nx = wcnt + 9'd1;
            if (DIN_LAST) begin
              commit   = 1'b1;
              cmt_nx   = wr_ptr + PTR_ONE;
              state_nx = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        if (DIN_WE && DIN_LAST) begin
          drop     = 1'b1;
          state_nx = W_IDLE;
        end
      end
      default: state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= W_IDLE;
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      wcnt    <= '0;
    end else begin
      state   <= state_nx;
      wr_ptr  <= wr_nx;
      cmt_ptr <= cmt_nx;
      wcnt    <= wcnt_nx;
    end
  end

  // Fetch only when the word can land in the output register, counting
  // the read already in flight and this cycle's consumption.
  assign DOUT_VALID = (ocnt != 2'd0);
  assign pop        = DOUT_VALID & DOUT_READY;
  assign last_pop   = pop & buf0.last;
  assign occ_nx     = {1'b0, ocnt} + {2'b0, pend} - {2'b0, pop};
  assign fetch      = (rd_ptr != cmt_ptr) && (occ_nx < 3'd2);
  assign DOUT       = buf0.data;
  assign DOUT_LAST  = buf0.last & DOUT_VALID;

  frame_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (fetch),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      pend   <= 1'b0;
      ocnt   <= 2'd0;
      buf0   <= '0;
      buf1   <= '0;
    end else begin
      if (fetch) rd_ptr <= rd_ptr + PTR_ONE;
      pend <= fetch;
      ocnt <= occ_nx[1:0];
      case ({pend, pop})
        2'b10: begin
          if (ocnt == 2'd0) buf0 <= rdata;
          else              buf1 <= rdata;
        end
        2'b01: buf0 <= buf1;
        2'b11: begin
          if (ocnt == 2'd1) begin
            buf0 <= rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FRAME_CNT    <= '0;
      DROP_CNT     <= '0;
      FRAMES_AVAIL <= '0;
    end else begin
      FRAME_CNT <= FRAME_CNT + {15'd0, commit};
      if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
      if (commit && !last_pop)      FRAMES_AVAIL <= FRAMES_AVAIL + 3'd1;
      else if (!commit && last_pop) FRAMES_AVAIL <= FRAMES_AVAIL - 3'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: table-driven frame stream checks plus hand-written
// latency, overflow and reset sequences.
`timescale 1ns/1ps
`default_nettype none
module tb_frame_buffer_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] DIN = '0;
  logic        DIN_WE = 1'b0;
  logic        DIN_LAST = 1'b0;
  logic [31:0] DOUT;
  logic        DOUT_VALID;
  logic        DOUT_READY;
  logic        DOUT_LAST;
  logic [2:0]  FRAMES_AVAIL;
  logic [15:0] FRAME_CNT;
  logic [15:0] DROP_CNT;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  logic [32:0] exp_q [$];
  bit          hold_chk = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;

  typedef struct {
    int          len;
    int          mode;
    bit          pass;
    bit          sync;
    logic [31:0] last_word;
    int          frames;
    int          drops;
  } vec_t;

  vec_t vecs [6];

  frame_buffer_ctrl dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .DIN          (DIN),
    .DIN_WE       (DIN_WE),
    .DIN_LAST     (DIN_LAST),
    .DOUT         (DOUT),
    .DOUT_VALID   (DOUT_VALID),
    .DOUT_READY   (DOUT_READY),
    .DOUT_LAST    (DOUT_LAST),
    .FRAMES_AVAIL (FRAMES_AVAIL),
    .FRAME_CNT    (FRAME_CNT),
    .DROP_CNT     (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0: ready low, 1: ready high, otherwise random 50%
  initial begin
    DOUT_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       DOUT_READY = 1'b0;
        1:       DOUT_READY = 1'b1;
        default: DOUT_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: consumed words must match the expected queue in order,
  // and a stalled word must stay put.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          checks++;
          if (!(DOUT_VALID && DOUT == hold_d && DOUT_LAST == hold_l)) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                     DOUT_VALID, DOUT, DOUT_LAST, hold_d, hold_l);
          end
        end
        if (DOUT_VALID && DOUT_READY) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got d=%h l=%b expected nothing", DOUT, DOUT_LAST);
          end else begin
            e = exp_q.pop_front();
            if ({DOUT_LAST, DOUT} !== e) begin
              errors++;
              $display("FAIL out_word: got l=%b d=%h expected l=%b d=%h",
                       DOUT_LAST, DOUT, e[32], e[31:0]);
            end
          end
        end
        hold_chk = DOUT_VALID && !DOUT_READY;
        hold_d   = DOUT;
        hold_l   = DOUT_LAST;
      end
    end
  end

  task automatic send_frame(input int len, input bit pass, input logic [7:0] tag,
                            input logic [31:0] last_word);
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      d        = (i == len - 1) ? last_word : {tag, 24'(i)};
      DIN_WE   = 1'b1;
      DIN      = d;
      DIN_LAST = (i == len - 1);
      if (pass) exp_q.push_back({DIN_LAST, d});
      @(posedge CLK);
      #1;
    end
    DIN_WE   = 1'b0;
    DIN_LAST = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0 && !DOUT_VALID) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_dout"},   DOUT, 32'h0);
    check({name, "_valid"},  32'(DOUT_VALID), 32'h0);
    check({name, "_last"},   32'(DOUT_LAST), 32'h0);
    check({name, "_avail"},  32'(FRAMES_AVAIL), 32'h0);
    check({name, "_frames"}, 32'(FRAME_CNT), 32'h0);
    check({name, "_drops"},  32'(DROP_CNT), 32'h0);
  endtask

  task automatic do_reset(input string name);
    RST_N    = 1'b0;
    DIN_WE   = 1'b0;
    DIN_LAST = 1'b0;
    exp_q.delete();
    @(posedge CLK);
    #1;
    check_zero(name);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{484, 1, 1'b1, 1'b1, 32'hF0F0F0F0, 2, 0};
    vecs[1] = '{490, 1, 1'b0, 1'b1, 32'h0BAD0BAD, 2, 1};
    vecs[2] = '{484, 1, 1'b1, 1'b1, 32'h12345678, 3, 1};
    vecs[3] = '{100, 2, 1'b1, 1'b0, 32'h33330001, 0, 0};
    vecs[4] = '{484, 2, 1'b1, 1'b0, 32'h44440002, 0, 0};
    vecs[5] = '{37,  2, 1'b1, 1'b1, 32'h55550003, 6, 1};

    #2 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset");
    RST_N = 1'b1;

    // One-word frame into an empty buffer: visible two edges after the write
    @(posedge CLK);
    #1;
    DIN = 32'hAAAAAAAA; DIN_WE = 1'b1; DIN_LAST = 1'b1;
    @(posedge CLK);
    #1;
    DIN_WE = 1'b0; DIN_LAST = 1'b0;
    check("lat_e0_valid", 32'(DOUT_VALID), 32'h0);
    @(posedge CLK);
    #1;
    check("lat_e1_valid", 32'(DOUT_VALID), 32'h0);
    @(posedge CLK);
    #1;
    check("lat_e2_valid", 32'(DOUT_VALID), 32'h1);
    check("lat_e2_dout", DOUT, 32'hAAAAAAAA);
    check("lat_e2_last", 32'(DOUT_LAST), 32'h1);
    check("lat_avail", 32'(FRAMES_AVAIL), 32'h1);
    exp_q.push_back({1'b1, 32'hAAAAAAAA});
    ready_mode = 1;
    wait_drain("lat");
    check("lat_frames", 32'(FRAME_CNT), 32'h1);

    for (int r = 0; r < 6; r++) begin
      ready_mode = vecs[r].mode;
      send_frame(vecs[r].len, vecs[r].pass, 8'(r + 1), vecs[r].last_word);
      if (vecs[r].sync) begin
        wait_drain("vec");
        repeat (2) @(posedge CLK);
        #1;
        check("vec_frames", 32'(FRAME_CNT), 32'(vecs[r].frames));
        check("vec_drops", 32'(DROP_CNT), 32'(vecs[r].drops));
        check("vec_avail", 32'(FRAMES_AVAIL), 32'h0);
      end
    end

    // Five full frames with the consumer stalled: the fifth cannot fit
    ready_mode = 0;
    for (int f = 0; f < 5; f++)
      send_frame(484, f < 4, 8'(8'h20 + f), 32'hE0000000 + 32'(f));
    repeat (4) @(posedge CLK);
    #1;
    check("ovf_avail", 32'(FRAMES_AVAIL), 32'h4);
    check("ovf_drops", 32'(DROP_CNT), 32'h2);
    check("ovf_frames", 32'(FRAME_CNT), 32'd10);
    check("ovf_valid", 32'(DOUT_VALID), 32'h1);
    check("ovf_head", DOUT, 32'h20000000);
    ready_mode = 1;
    wait_drain("ovf");
    check("ovf_avail_end", 32'(FRAMES_AVAIL), 32'h0);

    // Reset in the middle of an incoming frame
    for (int i = 0; i < 200; i++) begin
      DIN_WE = 1'b1; DIN = 32'hDEAD0000 + 32'(i); DIN_LAST = 1'b0;
      @(posedge CLK);
      #1;
    end
    do_reset("rst_wr");
    send_frame(484, 1'b1, 8'h40, 32'h40FFFFFF);
    wait_drain("rst_wr");
    check("rst_wr_frames", 32'(FRAME_CNT), 32'h1);

    // Reset while a committed frame is being read out
    send_frame(484, 1'b1, 8'h50, 32'h50FFFFFF);
    repeat (100) @(posedge CLK);
    #1;
    do_reset("rst_rd");
    send_frame(50, 1'b1, 8'h60, 32'h60FFFFFF);
    wait_drain("rst_rd");
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rd_frames", 32'(FRAME_CNT), 32'h1);
    check("rst_rd_avail", 32'(FRAMES_AVAIL), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
